// File: rtl/paddle_collision.sv
// paddle_collision
//
// Detects a ball touching the right-hand paddle and requests a bounce. It also
// flags a ball that has gone past the paddle and watches the bounce handshake
// with the ball logic. All outputs are registered and appear one clock after
// the qualifying inputs are sampled.
//
// Ports
//   clock        system clock (single domain)
//   reset        synchronous, active-high reset
//   enable       game tick; collision evaluation only happens while high
//   ball_x       ball x position (8 bit)
//   ball_y       ball top edge (9 bit)
//   ball_dir     1 = ball moving right, 0 = moving left
//   paddle_y     paddle top edge (9 bit)
//   x_bounce     request to reverse the ball's x direction
//   y_bounce     bit1 = top-half hit, bit0 = bottom-half hit
//   miss         one-cycle pulse when the ball passes the paddle
//   timeout_err  sticky: ball logic never acknowledged a bounce
//   hit_count    saturating paddle hit counter
//
// Build option
//   PADDLE_COLLISION_SCORE_EN  when defined, hit_count counts paddle hits.
//                              When undefined, hit_count is tied to 0 and no
//                              counter register exists.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ARMED  | waiting for the ball to reach the paddle face or the miss line
// HIT    | bounce requested; holding it until ball_dir returns 0
// MISSED | ball lost (or handshake expired); waiting for ball_x < PADDLE_X

module paddle_collision #(
  parameter int unsigned PADDLE_X      = 210,
  parameter int unsigned MISS_X        = 218,
  parameter int unsigned PADDLE_HEIGHT = 40,
  parameter int unsigned BALL_SIZE     = 4,
  parameter int unsigned HOLD_MAX      = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic       ball_dir,
  input  logic [8:0] paddle_y,
  output logic       x_bounce,
  output logic [1:0] y_bounce,
  output logic       miss,
  output logic       timeout_err,
  output logic [6:0] hit_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [7:0]        LP_PADDLE_X  = 8'(PADDLE_X);
  localparam logic [7:0]        LP_MISS_X    = 8'(MISS_X);
  localparam logic [9:0]        LP_BALL_SIZE = 10'(BALL_SIZE);
  localparam logic [9:0]        LP_BALL_HALF = 10'(BALL_SIZE / 2);
  localparam logic [9:0]        LP_PAD_H     = 10'(PADDLE_HEIGHT);
  localparam logic [9:0]        LP_PAD_HALF  = 10'(PADDLE_HEIGHT / 2);
  localparam logic [HOLD_W-1:0] LP_HOLD_MAX  = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] LP_HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    HIT    = 2'd1,
    MISSED = 2'd2
  } state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_x_bounce;
  logic [1:0]        r_y_bounce;
  logic              r_miss;
  logic              r_timeout_err;

  // Geometry is done at 10 bits so y + size / y + height never wrap.
  logic [9:0]        w_ball_y;
  logic [9:0]        w_pad_y;
  logic              w_overlap;
  logic              w_top_half;
  logic              w_hit_cond;
  logic              w_miss_cond;
  logic [HOLD_W-1:0] w_hold_nxt;

  assign w_ball_y    = {1'b0, ball_y};
  assign w_pad_y     = {1'b0, paddle_y};
  assign w_overlap   = ((w_ball_y + LP_BALL_SIZE) > w_pad_y) &&
                       (w_ball_y < (w_pad_y + LP_PAD_H));
  // Ball centre above paddle centre -> top half.
  assign w_top_half  = (w_ball_y + LP_BALL_HALF) < (w_pad_y + LP_PAD_HALF);
  assign w_hit_cond  = enable && ball_dir && (ball_x >= LP_PADDLE_X) && w_overlap;
  assign w_miss_cond = enable && ball_dir && (ball_x >= LP_MISS_X) && !w_overlap;
  assign w_hold_nxt  = r_hold + LP_HOLD_ONE;

`ifdef PADDLE_COLLISION_SCORE_EN
  logic [6:0] r_hit_count;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ARMED;
      r_hold        <= '0;
      r_x_bounce    <= 1'b0;
      r_y_bounce    <= 2'b00;
      r_miss        <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef PADDLE_COLLISION_SCORE_EN
      r_hit_count   <= 7'd0;
`endif
    end else begin
      // miss is a single-cycle pulse; only the ARMED->MISSED edge raises it.
      r_miss <= 1'b0;
      case (r_state)
        ARMED: begin
          // Hit is tested first so a touching ball past MISS_X still bounces.
          if (w_hit_cond) begin
            r_state    <= HIT;
            r_x_bounce <= 1'b1;
            r_y_bounce <= w_top_half ? 2'b10 : 2'b01;
            r_hold     <= '0;
`ifdef PADDLE_COLLISION_SCORE_EN
            if (r_hit_count != 7'd127) begin
              r_hit_count <= r_hit_count + 7'd1;
            end
`endif
          end else if (w_miss_cond) begin
            r_state <= MISSED;
            r_miss  <= 1'b1;
          end
        end
        HIT: begin
          // ball_dir = 0 is the acknowledge; it is honoured even without a tick.
          if (!ball_dir) begin
            r_state    <= ARMED;
            r_x_bounce <= 1'b0;
            r_y_bounce <= 2'b00;
          end else if (w_hold_nxt == LP_HOLD_MAX) begin
            r_state       <= MISSED;
            r_hold        <= w_hold_nxt;
            r_x_bounce    <= 1'b0;
            r_y_bounce    <= 2'b00;
            r_timeout_err <= 1'b1;
          end else begin
            r_hold <= w_hold_nxt;
          end
        end
        MISSED: begin
          if (ball_x < LP_PADDLE_X) begin
            r_state <= ARMED;
          end
        end
        default: begin
          r_state <= ARMED;
        end
      endcase
    end
  end

  assign x_bounce    = r_x_bounce;
  assign y_bounce    = r_y_bounce;
  assign miss        = r_miss;
  assign timeout_err = r_timeout_err;

`ifdef PADDLE_COLLISION_SCORE_EN
  assign hit_count = r_hit_count;
`else
  assign hit_count = 7'd0;
`endif

endmodule

// File: tb/tb_paddle_collision.sv
module tb_paddle_collision;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_dir;
  logic [8:0] paddle_y;
  logic       x_bounce;
  logic [1:0] y_bounce;
  logic       miss;
  logic       timeout_err;
  logic [6:0] hit_count;

  paddle_collision dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_dir    (ball_dir),
    .paddle_y    (paddle_y),
    .x_bounce    (x_bounce),
    .y_bounce    (y_bounce),
    .miss        (miss),
    .timeout_err (timeout_err),
    .hit_count   (hit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       xb;
    logic [1:0] yb;
    logic       mi;
    logic       te;
    logic [6:0] hc;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_hits = 0;

  // staged inputs, applied on the next falling edge by step()
  logic       s_reset = 1'b1;
  logic       s_en    = 1'b0;
  logic [7:0] s_bx    = 8'd0;
  logic [8:0] s_by    = 9'd0;
  logic       s_dir   = 1'b0;
  logic [8:0] s_py    = 9'd0;

  function automatic logic [6:0] exp_hc();
`ifdef PADDLE_COLLISION_SCORE_EN
    return (exp_hits > 127) ? 7'd127 : 7'(exp_hits);
`else
    return 7'd0;
`endif
  endfunction

  // Apply staged inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic exb, input logic [1:0] eyb, input logic emi,
                      input logic ete, input string nm);
    exp_t e;
    @(negedge clock);
    reset    = s_reset;
    enable   = s_en;
    ball_x   = s_bx;
    ball_y   = s_by;
    ball_dir = s_dir;
    paddle_y = s_py;
    e.xb = exb; e.yb = eyb; e.mi = emi; e.te = ete; e.hc = exp_hc(); e.nm = nm;
    q.push_back(e);
    @(posedge clock);
  endtask

  task automatic do_hit(input logic [7:0] bx, input logic [8:0] by, input logic [8:0] py,
                        input logic [1:0] eyb, input logic ete, input string nm);
    s_en = 1'b1; s_dir = 1'b1; s_bx = bx; s_by = by; s_py = py;
    exp_hits++;
    step(1'b1, eyb, 1'b0, ete, nm);
  endtask

  task automatic do_release(input logic ete, input string nm);
    s_dir = 1'b0;
    step(1'b0, 2'b00, 1'b0, ete, nm);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({x_bounce, y_bounce, miss, timeout_err, hit_count} !==
            {e.xb, e.yb, e.mi, e.te, e.hc}) begin
          n_err++;
          $display("FAIL %s: got xb=%b yb=%b miss=%b terr=%b hc=%0d, want xb=%b yb=%b miss=%b terr=%b hc=%0d",
                   e.nm, x_bounce, y_bounce, miss, timeout_err, hit_count,
                   e.xb, e.yb, e.mi, e.te, e.hc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of stimulus, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; ball_x = '0; ball_y = '0; ball_dir = 1'b0; paddle_y = '0;

    step(0, 2'b00, 0, 0, "reset0");
    step(0, 2'b00, 0, 0, "reset1");
    s_reset = 1'b0;
    step(0, 2'b00, 0, 0, "idle");

    // top-half hit and handshake
    do_hit(8'd210, 9'd205, 9'd200, 2'b10, 0, "top_hit");
    step(1, 2'b10, 0, 0, "top_hold");
    do_release(0, "top_release");
    step(0, 2'b00, 0, 0, "top_armed");

    // bottom-half hit
    do_hit(8'd210, 9'd230, 9'd200, 2'b01, 0, "bot_hit");
    step(1, 2'b01, 0, 0, "bot_hold1");
    step(1, 2'b01, 0, 0, "bot_hold2");
    do_release(0, "bot_release");

    // overlap and half boundaries
    s_en = 1'b1; s_dir = 1'b1; s_bx = 8'd210; s_py = 9'd200; s_by = 9'd196;
    step(0, 2'b00, 0, 0, "no_overlap_above");
    s_by = 9'd240;
    step(0, 2'b00, 0, 0, "no_overlap_below");
    do_hit(8'd210, 9'd197, 9'd200, 2'b10, 0, "edge_overlap_top");
    do_release(0, "edge_top_rel");
    do_hit(8'd210, 9'd217, 9'd200, 2'b10, 0, "half_top_side");
    do_release(0, "half_top_rel");
    do_hit(8'd210, 9'd218, 9'd200, 2'b01, 0, "half_bot_side");
    do_release(0, "half_bot_rel");
    s_dir = 1'b1; s_bx = 8'd209; s_by = 9'd205;
    step(0, 2'b00, 0, 0, "x_below_paddle");

    // hit wins over miss when both qualify
    do_hit(8'd220, 9'd205, 9'd200, 2'b10, 0, "hit_over_miss");
    do_release(0, "hit_over_miss_rel");

    // miss ramp and re-arm
    s_en = 1'b1; s_dir = 1'b1; s_py = 9'd100; s_by = 9'd300;
    for (int x = 200; x < 218; x++) begin
      s_bx = 8'(x);
      step(0, 2'b00, 0, 0, "ramp_no_miss");
    end
    s_bx = 8'd218;
    step(0, 2'b00, 1, 0, "miss_pulse");
    s_bx = 8'd219;
    step(0, 2'b00, 0, 0, "missed_hold");
    s_bx = 8'd20;
    step(0, 2'b00, 0, 0, "rearm");
    do_hit(8'd212, 9'd110, 9'd100, 2'b10, 0, "hit_after_rearm");
    do_release(0, "rearm_rel");

    // gated tick
    s_en = 1'b0; s_dir = 1'b1; s_bx = 8'd210; s_by = 9'd205; s_py = 9'd200;
    for (int i = 0; i < 10; i++) step(0, 2'b00, 0, 0, "gated");
    do_hit(8'd210, 9'd205, 9'd200, 2'b10, 0, "gated_release_hit");
    s_en = 1'b0;
    do_release(0, "release_no_tick");

    // handshake timeout
    do_hit(8'd210, 9'd205, 9'd200, 2'b10, 0, "to_hit");
    for (int k = 1; k < 255; k++) step(1, 2'b10, 0, 0, "to_holding");
    step(0, 2'b00, 0, 1, "timeout");
    step(0, 2'b00, 0, 1, "to_missed_stuck1");
    step(0, 2'b00, 0, 1, "to_missed_stuck2");
    s_bx = 8'd20;
    step(0, 2'b00, 0, 1, "to_rearm");
    do_hit(8'd210, 9'd205, 9'd200, 2'b10, 1, "to_sticky_hit");
    do_release(1, "to_sticky_rel");

    // reset in HIT
    do_hit(8'd210, 9'd205, 9'd200, 2'b10, 1, "pre_reset_hit");
    s_reset = 1'b1; exp_hits = 0;
    step(0, 2'b00, 0, 0, "reset_mid_hit");
    s_reset = 1'b0; s_dir = 1'b0;
    step(0, 2'b00, 0, 0, "post_reset_idle");

    // reset in MISSED
    s_en = 1'b1; s_dir = 1'b1; s_py = 9'd100; s_by = 9'd300; s_bx = 8'd218;
    step(0, 2'b00, 1, 0, "pre_reset_miss");
    s_reset = 1'b1;
    step(0, 2'b00, 0, 0, "reset_mid_missed");
    s_reset = 1'b0; s_bx = 8'd20;
    step(0, 2'b00, 0, 0, "post_reset_armed");

    // counter saturation
    for (int n = 0; n < 130; n++) begin
      do_hit(8'd210, 9'd205, 9'd200, 2'b10, 0, "sat_hit");
      do_release(0, "sat_rel");
    end

    @(negedge clock);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
